// File: rtl/stoch_pkg.sv
// Shared types and defaults for the stochastic bitstream decoder.
package stoch_pkg;

  localparam int DATA_W = 8;
  localparam int WINDOW_LOG2 = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } dec_state_t;

  typedef logic [DATA_W-1:0] prob_t;

endpackage

// File: rtl/stoch_ones_counter.sv
// Window counters: valid samples seen and ones among them, with a flag on the
// sample that closes the window.
module stoch_ones_counter #(
  parameter int WINDOW_LOG2 = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic                 bit_i,
  output logic [WINDOW_LOG2:0] ones_cnt_o,
  output logic                 last_sample_o
);

  logic [WINDOW_LOG2-1:0] sample_cnt_q, sample_cnt_d;
  logic [WINDOW_LOG2:0]   ones_cnt_q, ones_cnt_d;

  always_comb begin
    sample_cnt_d = sample_cnt_q;
    ones_cnt_d   = ones_cnt_q;
    if (clr_i) begin
      sample_cnt_d = '0;
      ones_cnt_d   = '0;
    end else if (en_i) begin
      sample_cnt_d = sample_cnt_q + 1'b1;
      ones_cnt_d   = ones_cnt_q + (WINDOW_LOG2 + 1)'(bit_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_cnt_q <= '0;
      ones_cnt_q   <= '0;
    end else begin
      sample_cnt_q <= sample_cnt_d;
      ones_cnt_q   <= ones_cnt_d;
    end
  end

  assign ones_cnt_o    = ones_cnt_q;
  assign last_sample_o = en_i && (sample_cnt_q == '1);

endmodule

// File: rtl/stoch_bit_decoder.sv
// Counts ones over 2^WINDOW_LOG2 valid samples and emits a DATA_W-bit estimate.
// Define STOCH_DEC_CONTINUOUS_EN to run windows back-to-back after the first start.
module stoch_bit_decoder #(
  parameter int DATA_W      = stoch_pkg::DATA_W,
  parameter int WINDOW_LOG2 = stoch_pkg::WINDOW_LOG2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   bit_valid,
  input  logic                   prob_bit,
  output logic                   busy,
  output logic                   est_valid,
  output logic [DATA_W-1:0]      prob_est,
  output stoch_pkg::dec_state_t  state_o
);
  import stoch_pkg::*;

  // Input qualification: prob_bit is a sample only when bit_valid=1 in ACCUM;
  // there is no backpressure, the decoder accepts every qualified bit.

  localparam int SHIFT = WINDOW_LOG2 - DATA_W;

  if (WINDOW_LOG2 < DATA_W) begin : g_param_check
    $error("stoch_bit_decoder: WINDOW_LOG2 must be >= DATA_W");
  end

  dec_state_t           state_q, state_d;
  logic [DATA_W-1:0]    prob_est_q, prob_est_d;
  logic                 cnt_clr, cnt_en, last_sample;
  logic [WINDOW_LOG2:0] ones_cnt, ones_final;

  assign cnt_en = (state_q == ACCUM) && bit_valid;

  stoch_ones_counter #(
    .WINDOW_LOG2 (WINDOW_LOG2)
  ) u_counter (
    .clk           (clk),
    .rst           (rst),
    .clr_i         (cnt_clr),
    .en_i          (cnt_en),
    .bit_i         (prob_bit),
    .ones_cnt_o    (ones_cnt),
    .last_sample_o (last_sample)
  );

  // The estimate is registered on the edge accepting the last sample so it is
  // already valid during the DONE cycle; that sample is folded in here.
  assign ones_final = ones_cnt + (WINDOW_LOG2 + 1)'(prob_bit);

  always_comb begin
    state_d    = state_q;
    prob_est_d = prob_est_q;
    cnt_clr    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          cnt_clr = 1'b1;
        end
      end
      ACCUM: begin
        if (last_sample) begin
          state_d    = DONE;
          prob_est_d = ones_final[WINDOW_LOG2] ? '1 : DATA_W'(ones_final >> SHIFT);
        end
      end
      DONE: begin
`ifdef STOCH_DEC_CONTINUOUS_EN
        state_d = ACCUM;
        cnt_clr = 1'b1;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      prob_est_q <= '0;
    end else begin
      state_q    <= state_d;
      prob_est_q <= prob_est_d;
    end
  end

  assign busy      = (state_q == ACCUM);
  assign est_valid = (state_q == DONE);
  assign prob_est  = prob_est_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_stoch_bit_decoder.sv
// Bench for stoch_bit_decoder: vector table, random windows vs. a counting model,
// reset/start-spam sequences and a 1024-sample instance.
`timescale 1ns/1ps
module tb_stoch_bit_decoder;
  import stoch_pkg::*;

  localparam int N8  = 256;
  localparam int N10 = 1024;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, bit_valid, prob_bit;
  logic       busy, est_valid;
  logic [7:0] prob_est;
  dec_state_t state;
  logic       start10, valid10, bit10;
  logic       busy10, est10;
  logic [7:0] prob10;
  dec_state_t state10;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp10_q[$];
  logic win_bits[N10];

  // clock / reset
  always #5 clk = ~clk;

  stoch_bit_decoder #(.DATA_W(8), .WINDOW_LOG2(8)) dut (
    .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid), .prob_bit(prob_bit),
    .busy(busy), .est_valid(est_valid), .prob_est(prob_est), .state_o(state)
  );

  stoch_bit_decoder #(.DATA_W(8), .WINDOW_LOG2(10)) dut10 (
    .clk(clk), .rst(rst), .start(start10), .bit_valid(valid10), .prob_bit(bit10),
    .busy(busy10), .est_valid(est10), .prob_est(prob10), .state_o(state10)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Reference model: fraction of ones scaled to 8 bits, truncated, saturated.
  function automatic logic [7:0] model_est(input int ones, input int wlog2);
    int n;
    n = 1 << wlog2;
    if (ones >= n) return 8'hFF;
    return 8'(ones / (n / 256));
  endfunction

  // scoreboard: every est_valid pulse must match the oldest expected window
  always @(negedge clk) begin
    if (est_valid === 1'b1) begin
      if (exp_q.size() == 0) check("est_valid_without_window", exp_q.size(), 1);
      else check("prob_est", prob_est, exp_q.pop_front());
    end
    if (est10 === 1'b1) begin
      if (exp10_q.size() == 0) check("est10_without_window", exp10_q.size(), 1);
      else check("prob_est_w10", prob10, exp10_q.pop_front());
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // driver tasks
  task automatic fill(input int pat);
    int dens;
    dens = $urandom_range(100, 0);
    for (int i = 0; i < N10; i++) begin
      case (pat)
        0:       win_bits[i] = 1'b1;
        1:       win_bits[i] = 1'b0;
        2:       win_bits[i] = (i % 2 == 0);
        3:       win_bits[i] = (i < 170);
        default: win_bits[i] = ($urandom_range(99, 0) < dens);
      endcase
    end
  endtask

  // stall: 0 none, 1 alternate valid/invalid, 2 random
  task automatic run_window(input int stall, input bit spam, input logic [7:0] exp, input string tag);
    int n = 0;
    int cyc = 0;
    int busy_bad = 0;
    bit v;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      start = 1'b0; bit_valid = 1'b1; prob_bit = 1'b1;
    end
    exp_q.push_back(exp);
    @(negedge clk);
    start = 1'b1; bit_valid = 1'b1; prob_bit = 1'b1;
    while (n < N8) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_bad++;
      start = spam;
      case (stall)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(1, 0) == 1) || (cyc >= 3 * N8);
      endcase
      bit_valid = v;
      prob_bit  = v ? win_bits[n] : 1'b1;
      if (v) n++;
      cyc++;
    end
    @(negedge clk);
    check({tag, "_latency"}, {30'd0, est_valid, busy}, 32'h2);
    check({tag, "_busy_cycles"}, busy_bad, 0);
    start = spam; bit_valid = 1'b1; prob_bit = 1'b1;
    @(negedge clk);
    start = 1'b0; bit_valid = 1'b0; prob_bit = 1'b0;
    check({tag, "_back_to_idle"}, {30'd0, busy, est_valid}, 0);
  endtask

  typedef struct {
    int         pat;
    int         stall;
    bit         spam;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int ones;
    rst = 1'b1; start = 1'b0; bit_valid = 1'b0; prob_bit = 1'b0;
    start10 = 1'b0; valid10 = 1'b0; bit10 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_est_valid", est_valid, 0);
    check("rst_prob_est", prob_est, 0);
    check("rst_state", state, IDLE);
    check("rst_prob_est_w10", prob10, 0);
    rst = 1'b0;

`ifdef STOCH_DEC_CONTINUOUS_EN
    @(negedge clk);
    start10 = 1'b1; valid10 = 1'b1; bit10 = 1'b1;
    for (int w = 0; w < 3; w++) begin
      ones = 0;
      for (int i = 0; i < N10; i++) begin
        @(negedge clk);
        if (w > 0 || i > 0) check("cont_busy", busy10, 1);
        start10 = 1'b0;
        bit10 = ($urandom_range(1, 0) == 1);
        ones += int'(bit10);
      end
      exp10_q.push_back(model_est(ones, 10));
      @(negedge clk);
      check("cont_period", {est10, busy10}, 2'b10);
      bit10 = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1; valid10 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("cont_rst_busy", busy10, 0);
`else
    vecs[0] = '{pat: 0, stall: 0, spam: 1'b0, exp: 8'hFF};
    vecs[1] = '{pat: 1, stall: 0, spam: 1'b0, exp: 8'h00};
    vecs[2] = '{pat: 2, stall: 0, spam: 1'b0, exp: 8'h80};
    vecs[3] = '{pat: 3, stall: 0, spam: 1'b0, exp: 8'hAA};
    vecs[4] = '{pat: 0, stall: 1, spam: 1'b0, exp: 8'hFF};
    vecs[5] = '{pat: 1, stall: 1, spam: 1'b0, exp: 8'h00};
    vecs[6] = '{pat: 2, stall: 0, spam: 1'b1, exp: 8'h80};
    for (int i = 0; i < 7; i++) begin
      fill(vecs[i].pat);
      run_window(vecs[i].stall, vecs[i].spam, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // estimate is held while idle
    repeat (4) @(negedge clk);
    check("hold_prob_est", prob_est, 8'h80);

    // reset part-way through a window
    fill(2);
    @(negedge clk);
    start = 1'b1; bit_valid = 1'b1; prob_bit = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      start = 1'b0; bit_valid = 1'b1; prob_bit = win_bits[i];
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; bit_valid = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_prob_est", prob_est, 0);
    check("midrst_est_valid", est_valid, 0);
    fill(3);
    run_window(0, 1'b0, 8'hAA, "after_rst");

    for (int r = 0; r < 4; r++) begin
      fill(4);
      ones = 0;
      for (int i = 0; i < N8; i++) ones += int'(win_bits[i]);
      run_window(2, 1'b0, model_est(ones, 8), $sformatf("rand%0d", r));
    end

    // 1024-sample window
    fill(2);
    exp10_q.push_back(8'h80);
    @(negedge clk);
    start10 = 1'b1; valid10 = 1'b1; bit10 = 1'b1;
    for (int i = 0; i < N10; i++) begin
      @(negedge clk);
      start10 = 1'b0; valid10 = 1'b1; bit10 = win_bits[i];
    end
    @(negedge clk);
    valid10 = 1'b0;
    check("w10_latency", {est10, busy10}, 2'b10);
    repeat (3) @(negedge clk);
    check("w10_hold", prob10, 8'h80);
`endif

    repeat (4) @(negedge clk);
    check("pending_estimates", exp_q.size() + exp10_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
